// File: rtl/button_event.sv
`timescale 1ns/1ps
// button_event: turns a debounced push-button level into single-cycle
// command events (press, release, long-press hold, auto-repeat) for the
// downstream control FSM. One instance per key.
//
// Ports:
//   clk            system clock
//   nReset         asynchronous active-low reset
//   level          debounced button level, synchronous to clk
//   press_pulse    one-cycle pulse on press
//   release_pulse  one-cycle pulse on release
//   hold_pulse     one-cycle pulse once the press has lasted HOLD_TIME cycles
//   repeat_pulse   one-cycle pulse every REPEAT_TIME cycles while held
//   pressed        registered "button down" level
//   held           high from hold_pulse until release
//
// Parameters:
//   ACTIVE_LOW   1 = level is 0 when pressed, 0 = level is 1 when pressed
//   HOLD_TIME    cycles from press_pulse to hold_pulse (>= 2)
//   REPEAT_TIME  cycles between repeats, and from hold_pulse to first repeat (>= 2)
//   REPEAT_EN    1 = emit repeat pulses while held
module button_event #(
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned HOLD_TIME   = 25000000,
  parameter int unsigned REPEAT_TIME = 5000000,
  parameter bit          REPEAT_EN   = 1'b1
) (
  input  logic clk,
  input  logic nReset,
  input  logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic repeat_pulse,
  output logic pressed,
  output logic held
);

  localparam int unsigned MAX_TIME = (HOLD_TIME > REPEAT_TIME) ? HOLD_TIME : REPEAT_TIME;
  localparam int unsigned CNT_W    = (MAX_TIME > 2) ? $clog2(MAX_TIME) : 1;

  // Terminal counts: the counter restarts at 0 on each event, so the event
  // fires on the edge that observes count N-1, exactly N cycles later.
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Level value that means "not pressed".
  localparam logic RELEASED = ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;

  logic press_d;
  logic release_d;
  logic hold_d;
  logic repeat_d;
  logic pressed_d;
  logic held_d;

  logic act;
  logic act_prev;
  logic press_evt;

  // Normalise polarity: act = 1 means the key is down.
  assign act      = level ^ ACTIVE_LOW;
  assign act_prev = level_q ^ ACTIVE_LOW;

  // Rising edge of act. level_q resets to the released value, so a key
  // already down when reset lifts is reported as a fresh press.
  assign press_evt = act & ~act_prev;

  // State, counter, previous level and registered outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      level_q       <= RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      hold_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      pressed       <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level_q       <= level;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      hold_pulse    <= hold_d;
      repeat_pulse  <= repeat_d;
      pressed       <= pressed_d;
      held          <= held_d;
    end
  end

  // Next-state, counter and next-output decode. Release is checked before
  // the terminal count so a release on that edge suppresses hold/repeat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;
    repeat_d  = 1'b0;
    pressed_d = pressed;
    held_d    = held;

    unique case (state_q)
      ST_IDLE: begin
        if (press_evt) begin
          state_d   = ST_PRESS;
          press_d   = 1'b1;
          pressed_d = 1'b1;
          cnt_d     = '0;
        end
      end

      ST_PRESS: begin
        if (!act) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          pressed_d = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_HELD;
          hold_d  = 1'b1;
          held_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HELD: begin
        if (!act) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          pressed_d = 1'b0;
          held_d    = 1'b0;
          cnt_d     = '0;
        end else if (REPEAT_EN) begin
          if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        pressed_d = 1'b0;
        held_d    = 1'b0;
      end
    endcase
  end

`ifndef SYNTHESIS
  // At most one event pulse per cycle.
  a_pulse_excl: assert property (@(posedge clk) disable iff (!nReset)
    $onehot0({press_pulse, release_pulse, hold_pulse, repeat_pulse}));

  // held is a sub-state of pressed.
  a_held_pressed: assert property (@(posedge clk) disable iff (!nReset)
    held |-> pressed);
`endif

endmodule

// File: tb/tb_button_event.sv
`timescale 1ns/1ps
// Bench for button_event: three instances (repeat on, repeat off,
// active-high) checked cycle by cycle against a run-length reference model,
// plus vector tables and hand-written corner-case sequences.
module tb_button_event;

  localparam int H = 8;
  localparam int R = 4;

  // Observation vector bit positions.
  localparam int P_PRESS   = 5;
  localparam int P_REL     = 4;
  localparam int P_HOLD    = 3;
  localparam int P_REP     = 2;
  localparam int P_PRESSED = 1;
  localparam int P_HELD    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_v;
  logic [2:0] lvl_v;
  logic [5:0] obs_a;
  logic [5:0] obs_b;
  logic [5:0] obs_c;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int run [3];

  typedef struct {
    logic       lvl;
    logic [5:0] exp;
  } vec_t;

  vec_t tab [11];

  button_event #(.ACTIVE_LOW(1'b1), .HOLD_TIME(H), .REPEAT_TIME(R), .REPEAT_EN(1'b1)) u_a (
    .clk(clk), .nReset(rst_v[0]), .level(lvl_v[0]),
    .press_pulse(obs_a[P_PRESS]), .release_pulse(obs_a[P_REL]),
    .hold_pulse(obs_a[P_HOLD]), .repeat_pulse(obs_a[P_REP]),
    .pressed(obs_a[P_PRESSED]), .held(obs_a[P_HELD]));

  button_event #(.ACTIVE_LOW(1'b1), .HOLD_TIME(H), .REPEAT_TIME(R), .REPEAT_EN(1'b0)) u_b (
    .clk(clk), .nReset(rst_v[1]), .level(lvl_v[1]),
    .press_pulse(obs_b[P_PRESS]), .release_pulse(obs_b[P_REL]),
    .hold_pulse(obs_b[P_HOLD]), .repeat_pulse(obs_b[P_REP]),
    .pressed(obs_b[P_PRESSED]), .held(obs_b[P_HELD]));

  button_event #(.ACTIVE_LOW(1'b0), .HOLD_TIME(H), .REPEAT_TIME(R), .REPEAT_EN(1'b1)) u_c (
    .clk(clk), .nReset(rst_v[2]), .level(lvl_v[2]),
    .press_pulse(obs_c[P_PRESS]), .release_pulse(obs_c[P_REL]),
    .hold_pulse(obs_c[P_HOLD]), .repeat_pulse(obs_c[P_REP]),
    .pressed(obs_c[P_PRESSED]), .held(obs_c[P_HELD]));

  function automatic bit al_of(input int i);
    return (i == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic bit ren_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [5:0] obs_of(input int i);
    case (i)
      0:       return obs_a;
      1:       return obs_b;
      default: return obs_c;
    endcase
  endfunction

  function automatic logic [5:0] mk(input bit p, input bit rl, input bit h,
                                    input bit rp, input bit pd, input bit hd);
    return {p, rl, h, rp, pd, hd};
  endfunction

  // Reference: run_n = number of consecutive pressed samples so far.
  // Press on the 1st, hold on the (H+1)th, repeats every R samples after that.
  function automatic logic [5:0] model(input int run_p, input bit act, input bit ren,
                                       output int run_n);
    logic [5:0] e;
    e = '0;
    if (act) begin
      run_n        = run_p + 1;
      e[P_PRESS]   = (run_n == 1);
      e[P_HOLD]    = (run_n == H + 1);
      e[P_REP]     = ren && (run_n > H + 1) && (((run_n - H - 1) % R) == 0);
      e[P_PRESSED] = 1'b1;
      e[P_HELD]    = (run_n > H);
    end else begin
      run_n    = 0;
      e[P_REL] = (run_p > 0);
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b (press,rel,hold,rep,pressed,held)",
               nm, cyc, got, exp);
    end
  endtask

  // One clock: sample #1 after the edge, score every instance against the model.
  task automatic step();
    logic [5:0] e;
    logic [5:0] g;
    int         rn;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (!rst_v[i]) begin
        run[i] = 0;
        e      = '0;
      end else begin
        e      = model(run[i], lvl_v[i] ^ al_of(i), ren_of(i), rn);
        run[i] = rn;
      end
      g = obs_of(i);
      check($sformatf("scb%0d", i), g, e);
      checks++;
      if (!$onehot0(g[5:2])) begin
        failures++;
        $display("FAIL excl%0d cyc=%0d pulses=%b required at most one high", i, cyc, g[5:2]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 3; i++) run[i] = 0;
    rst_v = 3'b000;
    lvl_v = 3'b011;

    tab[0]  = '{1'b1, 6'b000000};
    tab[1]  = '{1'b0, 6'b100010};
    tab[2]  = '{1'b0, 6'b000010};
    tab[3]  = '{1'b0, 6'b000010};
    tab[4]  = '{1'b1, 6'b010000};
    tab[5]  = '{1'b1, 6'b000000};
    tab[6]  = '{1'b0, 6'b100010};
    tab[7]  = '{1'b1, 6'b010000};
    tab[8]  = '{1'b0, 6'b100010};
    tab[9]  = '{1'b1, 6'b010000};
    tab[10] = '{1'b1, 6'b000000};

    // Reset state.
    repeat (3) step();
    rst_v = 3'b111;
    repeat (2) step();

    // Short, one-cycle and back-to-back presses.
    for (int i = 0; i < 11; i++) begin
      lvl_v[0] = tab[i].lvl;
      step();
      check("vec", obs_a, tab[i].exp);
    end

    // Long hold with repeats (A) and without repeats (B).
    for (int k = 0; k <= 30; k++) begin
      lvl_v[0] = (k == 30);
      lvl_v[1] = (k == 30);
      step();
      check("hold_a", obs_a, mk(k == 0, k == 30, k == 8,
                                (k > 8) && (k < 30) && (((k - 8) % 4) == 0),
                                k < 30, (k >= 8) && (k < 30)));
      check("hold_b", obs_b, mk(k == 0, k == 30, k == 8, 1'b0,
                                k < 30, (k >= 8) && (k < 30)));
    end
    repeat (2) step();

    // Release on the edge that would have produced hold_pulse.
    for (int k = 0; k <= 8; k++) begin
      lvl_v[0] = (k == 8);
      step();
      check("term", obs_a, mk(k == 0, k == 8, 1'b0, 1'b0, k < 8, 1'b0));
    end
    repeat (2) step();

    // Reset while held: outputs clear at once, no release, then a fresh press.
    for (int k = 0; k <= 14; k++) begin
      lvl_v[0] = 1'b0;
      step();
    end
    check("pre_rst_held", obs_a, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    rst_v[0] = 1'b0;
    #1;
    check("rst_async", obs_a, 6'b000000);
    step();
    check("rst_hold", obs_a, 6'b000000);
    step();
    check("rst_hold", obs_a, 6'b000000);
    rst_v[0] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      check("rst_after", obs_a, mk(k == 0, 1'b0, k == 8, 1'b0, 1'b1, k == 8));
    end
    lvl_v[0] = 1'b1;
    step();
    check("rst_rel", obs_a, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    step();

    // Active-high key pressed for three samples.
    for (int k = 0; k <= 3; k++) begin
      lvl_v[2] = (k < 3);
      step();
      check("ahigh", obs_c, mk(k == 0, k == 3, 1'b0, 1'b0, k < 3, 1'b0));
    end
    step();

    // Random levels with occasional resets on A.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 9) == 0) lvl_v[i] = ~lvl_v[i];
      end
      rst_v[0] = ($urandom_range(0, 149) != 0);
      step();
    end
    rst_v = 3'b111;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
